// File: rtl/ysyx_22051013_mem_arbiter_if.sv
// rtl/ysyx_22051013_mem_arbiter_if.sv - icache/dcache request and memory-bus signal bundle for the arbiter
// master = arbiter side (drives m_* and responses), slave = requesters plus downstream wrapper.
interface ysyx_22051013_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic [DATA_W-1:0] m_rdata;
    logic              m_done;

    logic              busy;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata, m_done,
        output i_rdata, i_valid, d_rdata, d_valid,
        output m_req, m_we, m_addr, m_wdata, m_wstrb, busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata, m_done,
        input  i_rdata, i_valid, d_rdata, d_valid,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb, busy
    );
endinterface

// File: rtl/ysyx_22051013_mem_arbiter.sv
// rtl/ysyx_22051013_mem_arbiter.sv - single memory-bus arbiter between icache refill and dcache/LSU
// Fixed dcache priority by default; define YSYX_22051013_ARB_RR_EN for round-robin on contention.
module ysyx_22051013_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input logic                           clk,
    input logic                           rst,
    ysyx_22051013_mem_arbiter_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              resp_d_q, resp_d_d;
    logic              grant_d;

`ifdef YSYX_22051013_ARB_RR_EN
    logic last_d_q, last_d_d;

    // On contention the requester not served last wins; last_d_q resets to "icache".
    assign grant_d = bus.d_req && (!bus.i_req || !last_d_q);
`else
    assign grant_d = bus.d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            resp_d_q  <= 1'b0;
`ifdef YSYX_22051013_ARB_RR_EN
            last_d_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            resp_d_q  <= resp_d_d;
`ifdef YSYX_22051013_ARB_RR_EN
            last_d_q  <= last_d_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        resp_d_d  = resp_d_q;
`ifdef YSYX_22051013_ARB_RR_EN
        last_d_d  = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = GNT_D;
                    we_d    = bus.d_we;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    wstrb_d = bus.d_we ? bus.d_wstrb : '0;
`ifdef YSYX_22051013_ARB_RR_EN
                    last_d_d = 1'b1;
`endif
                end else if (bus.i_req) begin
                    state_d = GNT_I;
                    we_d    = 1'b0;
                    addr_d  = bus.i_addr;
                    wdata_d = '0;
                    wstrb_d = '0;
`ifdef YSYX_22051013_ARB_RR_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            GNT_I: begin
                if (bus.m_done) begin
                    state_d   = RESP;
                    i_rdata_d = bus.m_rdata;
                    resp_d_d  = 1'b0;
                end
            end
            GNT_D: begin
                if (bus.m_done) begin
                    state_d   = RESP;
                    d_rdata_d = we_q ? '0 : bus.m_rdata;
                    resp_d_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a pure function of registered state, so nothing upstream leaks downstream mid-grant.
    always_comb begin
        bus.m_req   = (state_q == GNT_I) || (state_q == GNT_D);
        bus.m_we    = we_q;
        bus.m_addr  = addr_q;
        bus.m_wdata = wdata_q;
        bus.m_wstrb = wstrb_q;
        bus.busy    = (state_q != IDLE);
        bus.i_valid = (state_q == RESP) && !resp_d_q;
        bus.d_valid = (state_q == RESP) && resp_d_q;
        bus.i_rdata = i_rdata_q;
        bus.d_rdata = d_rdata_q;
    end
endmodule

// File: tb/tb_ysyx_22051013_mem_arbiter.sv
// tb/tb_ysyx_22051013_mem_arbiter.sv - vector table plus response scoreboard for the memory arbiter
module tb_ysyx_22051013_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22051013_mem_arbiter_if bus ();

    ysyx_22051013_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        is_d;
        logic [63:0] rdata;
    } exp_t;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] rdata;
        int          delay;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wstrb;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic exp_we, input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                         input logic [7:0] exp_wstrb, input int delay, input logic [63:0] rdata,
                         input logic chg_d);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.m_req && n < 8) begin
            tick();
            n++;
        end
        chk("grant_seen", {63'd0, bus.m_req}, 64'd1);
        if (!bus.m_req) return;
        chk("m_we", {63'd0, bus.m_we}, {63'd0, exp_we});
        chk("m_addr", bus.m_addr, exp_addr);
        chk("m_wdata", bus.m_wdata, exp_wdata);
        chk("m_wstrb", {56'd0, bus.m_wstrb}, {56'd0, exp_wstrb});
        chk("busy_gnt", {63'd0, bus.busy}, 64'd1);
        if (chg_d) bus.d_addr = ~exp_addr;
        repeat (delay) tick();
        chk("m_addr_held", bus.m_addr, exp_addr);
        chk("m_req_held", {63'd0, bus.m_req}, 64'd1);
        bus.m_done  = 1'b1;
        bus.m_rdata = rdata;
        tick();
        bus.m_done  = 1'b0;
        bus.m_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        e = '{is_d: 1'b0, rdata: 64'd0};
        chk("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) e = sb.pop_front();
        chk("i_valid", {63'd0, bus.i_valid}, {63'd0, !e.is_d});
        chk("d_valid", {63'd0, bus.d_valid}, {63'd0, e.is_d});
        chk("rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
        chk("m_req_resp", {63'd0, bus.m_req}, 64'd0);
        if (e.is_d) bus.d_req = 1'b0;
        else        bus.i_req = 1'b0;
        tick();
        chk("i_valid_off", {63'd0, bus.i_valid}, 64'd0);
        chk("d_valid_off", {63'd0, bus.d_valid}, 64'd0);
        chk("busy_idle", {63'd0, bus.busy}, 64'd0);
    endtask

    vec_t vecs[5];
    logic last_d;
    logic win_d;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 64'h8000_0008, 64'h0,    8'h00, 64'h1122_3344_5566_7788, 3, 64'h0,    8'h00};
        vecs[1] = '{1'b1, 1'b1, 64'h8000_1000, 64'hDEAD, 8'h0F, 64'h5555_5555_5555_5555, 2, 64'hDEAD, 8'h0F};
        vecs[2] = '{1'b1, 1'b0, 64'h8000_1008, 64'hBEEF, 8'hFF, 64'hCAFE_F00D_1234_5678, 0, 64'hBEEF, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 64'h8000_0010, 64'h0,    8'h00, 64'hFFFF_0000_FFFF_0000, 1, 64'h0,    8'h00};
        vecs[4] = '{1'b1, 1'b1, 64'h8000_1010, 64'h0123, 8'hF0, 64'h9999_8888_7777_6666, 1, 64'h0123, 8'hF0};

        rst         = 1'b1;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        bus.i_addr  = 64'h8000_0000;
        bus.d_we    = 1'b0;
        bus.d_addr  = 64'h8000_3000;
        bus.d_wdata = 64'h0;
        bus.d_wstrb = 8'h00;
        bus.m_rdata = 64'h0;
        bus.m_done  = 1'b0;

        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_busy", {63'd0, bus.busy}, 64'd0);
            chk("rst_m_req", {63'd0, bus.m_req}, 64'd0);
            chk("rst_valids", {62'd0, bus.i_valid, bus.d_valid}, 64'd0);
            chk("rst_m_addr", bus.m_addr, 64'd0);
            chk("rst_rdata", bus.i_rdata | bus.d_rdata, 64'd0);
            chk("rst_m_wstrb_we", {55'd0, bus.m_wstrb, bus.m_we}, 64'd0);
        end
        rst = 1'b0;
        tick();
        chk("first_grant_after_rst", {63'd0, bus.m_req}, 64'd1);
        sb.push_back('{is_d: 1'b1, rdata: 64'h0000_1111_2222_3333});
        serve(1'b0, 64'h8000_3000, 64'h0, 8'h00, 1, 64'h0000_1111_2222_3333, 1'b0);
        sb.push_back('{is_d: 1'b0, rdata: 64'h4444_5555_6666_7777});
        serve(1'b0, 64'h8000_0000, 64'h0, 8'h00, 2, 64'h4444_5555_6666_7777, 1'b0);

        bus.m_done  = 1'b1;
        bus.m_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        bus.m_done = 1'b0;
        chk("stray_done_busy", {63'd0, bus.busy}, 64'd0);
        chk("stray_done_m_req", {63'd0, bus.m_req}, 64'd0);
        chk("stray_done_valids", {62'd0, bus.i_valid, bus.d_valid}, 64'd0);
        tick();
        chk("stray_done_valids2", {62'd0, bus.i_valid, bus.d_valid}, 64'd0);
        chk("stray_done_rdata", bus.i_rdata, 64'h4444_5555_6666_7777);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_d) begin
                bus.d_req   = 1'b1;
                bus.d_we    = vecs[i].we;
                bus.d_addr  = vecs[i].addr;
                bus.d_wdata = vecs[i].wdata;
                bus.d_wstrb = vecs[i].wstrb;
            end else begin
                bus.i_req  = 1'b1;
                bus.i_addr = vecs[i].addr;
            end
            sb.push_back('{is_d: vecs[i].is_d, rdata: vecs[i].we ? 64'd0 : vecs[i].rdata});
            serve(vecs[i].we, vecs[i].addr, vecs[i].exp_wdata, vecs[i].exp_wstrb,
                  vecs[i].delay, vecs[i].rdata, vecs[i].is_d);
        end

        bus.i_addr = 64'h8000_0040;
        bus.i_req  = 1'b1;
        tick();
        chk("mid_rst_pre_m_req", {63'd0, bus.m_req}, 64'd1);
        rst       = 1'b1;
        bus.i_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_rst_m_req", {63'd0, bus.m_req}, 64'd0);
        chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("mid_rst_m_addr", bus.m_addr, 64'd0);
        chk("mid_rst_rdata", bus.i_rdata | bus.d_rdata, 64'd0);
        tick();
        chk("mid_rst_no_valid", {62'd0, bus.i_valid, bus.d_valid}, 64'd0);
        chk("mid_rst_idle", {63'd0, bus.busy}, 64'd0);

        last_d      = 1'b0;
        bus.i_addr  = 64'h8000_0100;
        bus.d_addr  = 64'h8000_2000;
        bus.d_we    = 1'b0;
        bus.d_wdata = 64'h77;
        bus.d_wstrb = 8'hFF;
        for (int g = 0; g < 4; g++) begin
            bus.i_req = 1'b1;
            bus.d_req = 1'b1;
`ifdef YSYX_22051013_ARB_RR_EN
            win_d = !last_d;
`else
            win_d = 1'b1;
`endif
            last_d = win_d;
            sb.push_back('{is_d: win_d, rdata: 64'h1000 + 64'(g)});
            serve(1'b0, win_d ? 64'h8000_2000 : 64'h8000_0100, win_d ? 64'h77 : 64'h0, 8'h00,
                  1, 64'h1000 + 64'(g), 1'b0);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        tick();
        chk("sb_drained", {32'd0, 32'(sb.size())}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
